jtpang_busarb: RTL

JTPANG_BUSARB -- requirements
Module: jtpang_busarb

---
 rtl/jtpang_busarb_if.sv | 28 ++
 rtl/jtpang_busarb.sv | 87 ++++++++
 2 files changed

// File: rtl/jtpang_busarb_if.sv
// Shared-RAM bus bundle between the CPU side, the object-engine DMA and the arbiter.
// The arbiter connects through the slave modport; the CPU/DMA environment uses master.
interface jtpang_busarb_if #(
  parameter int LENW = 10
);
  logic            cpu_cen;
  logic            busrq;
  logic            busak_n;
  logic            cpu_mreq_n;
  logic            cpu_hold;
  logic [11:0]     cpu_addr;
  logic            cpu_wr_n;
  logic [8:0]      dma_addr;
  logic            dma_sel;
  logic [11:0]     mem_addr;
  logic            mem_wr_n;
  logic [LENW-1:0] dma_len;

  modport slave (
    input  cpu_cen, busrq, cpu_mreq_n, cpu_addr, cpu_wr_n, dma_addr,
    output busak_n, cpu_hold, dma_sel, mem_addr, mem_wr_n, dma_len
  );

  modport master (
    output cpu_cen, busrq, cpu_mreq_n, cpu_addr, cpu_wr_n, dma_addr,
    input  busak_n, cpu_hold, dma_sel, mem_addr, mem_wr_n, dma_len
  );
endinterface

// File: rtl/jtpang_busarb.sv
// Arbiter handing the shared RAM between the CPU and the object-engine DMA.
// The CPU is frozen through cpu_hold before the DMA is acknowledged, and the grant length is measured.
module jtpang_busarb #(
  parameter logic [11:0] DMA_BASE = 12'hE00,
  parameter int          LENW     = 10
) (
  input  logic                  rst,
  input  logic                  clk,
  jtpang_busarb_if.slave        bus,
  output logic [1:0]            dbg_state
);

  // Encoding is exported on dbg_state: 0 IDLE, 1 HOLD, 2 GRANT, 3 REL.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    GRANT = 2'd2,
    REL   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            busak_n_q, busak_n_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            dma_sel_q, dma_sel_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [LENW-1:0] dma_len_q, dma_len_d;
  logic [LENW-1:0] cnt_inc;

  always_comb begin
    state_d    = state_q;
    busak_n_d  = busak_n_q;
    cpu_hold_d = cpu_hold_q;
    dma_sel_d  = dma_sel_q;
    cnt_d      = cnt_q;
    dma_len_d  = dma_len_q;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    if (bus.cpu_cen) begin
      case (state_q)
        // Only request the bus between CPU memory cycles.
        IDLE:    if (bus.busrq && bus.cpu_mreq_n) state_d = HOLD;
        HOLD:    state_d = bus.busrq ? GRANT : IDLE;
        GRANT:   if (!bus.busrq) state_d = REL;
        REL:     state_d = IDLE;
        default: state_d = IDLE;
      endcase

      busak_n_d  = (state_d != GRANT);
      cpu_hold_d = (state_d != IDLE);
      dma_sel_d  = (state_d == GRANT);

      // The counter records every tick the FSM spends in GRANT, including the releasing one.
      if (state_q == GRANT)      cnt_d = cnt_inc;
      else if (state_d == GRANT) cnt_d = '0;

      if (state_q == GRANT && state_d == REL) dma_len_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busak_n_q  <= 1'b1;
      cpu_hold_q <= 1'b0;
      dma_sel_q  <= 1'b0;
      cnt_q      <= '0;
      dma_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      busak_n_q  <= busak_n_d;
      cpu_hold_q <= cpu_hold_d;
      dma_sel_q  <= dma_sel_d;
      cnt_q      <= cnt_d;
      dma_len_q  <= dma_len_d;
    end
  end

  assign bus.busak_n  = busak_n_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.dma_sel  = dma_sel_q;
  assign bus.dma_len  = dma_len_q;
  // DMA only reads, so the RAM write strobe is forced inactive while it owns the bus.
  assign bus.mem_addr = dma_sel_q ? {DMA_BASE[11:9], bus.dma_addr} : bus.cpu_addr;
  assign bus.mem_wr_n = dma_sel_q ? 1'b1 : bus.cpu_wr_n;
  assign dbg_state    = state_q;

endmodule
